// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector: history shift register, parallel
// window comparator and saturating match counter, Mealy or Moore match output.
module seq_detector_param #(
    parameter int SYM_W   = 2,
    parameter int PAT_LEN = 3,
    parameter int OVERLAP = 1,
    parameter int MOORE   = 0,
    parameter int CNT_W   = 8,
    parameter logic [SYM_W*PAT_LEN-1:0] RESET_PAT = {2'b10, 2'b10, 2'b01}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pat_load,
    input  logic [SYM_W*PAT_LEN-1:0] pat_in,
    input  logic                     sym_valid,
    input  logic [SYM_W-1:0]         sym_in,
    input  logic                     cnt_clr,
    output logic                     z,
    output logic [CNT_W-1:0]         match_cnt,
    output logic [4:0]               fill
);

    localparam int                PW       = SYM_W * PAT_LEN;
    localparam int                HW       = SYM_W * (PAT_LEN - 1);
    localparam logic [4:0]        FILL_MAX = 5'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [PW-1:0]    pat_r;
    logic [HW-1:0]    hist_r;
    logic [4:0]       fill_r;
    logic [CNT_W-1:0] cnt_r;
    logic             z_r;

    logic             accept_s;
    logic             hit_s;
    logic [PW-1:0]    window_s;
    logic [HW-1:0]    hist_nxt_s;
    logic [4:0]       fill_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Window compare plus next-state for history, fill and counter.
    always_comb begin
        accept_s   = sym_valid & ~pat_load & ~reset;
        // Oldest history symbol sits in the LSBs, so the newest symbol lands on top.
        window_s   = {sym_in, hist_r};
        hit_s      = accept_s && (fill_r == FILL_MAX) && (window_s == pat_r);
        hist_nxt_s = hist_r;
        fill_nxt_s = fill_r;
        cnt_nxt_s  = cnt_r;

        if (pat_load) begin
            hist_nxt_s = {HW{1'b0}};
            fill_nxt_s = 5'd0;
        end else if (hit_s && (OVERLAP == 0)) begin
            hist_nxt_s = {HW{1'b0}};
            fill_nxt_s = 5'd0;
        end else if (accept_s) begin
            hist_nxt_s = window_s[PW-1:SYM_W];
            fill_nxt_s = (fill_r == FILL_MAX) ? fill_r : fill_r + 5'd1;
        end else begin
            hist_nxt_s = hist_r;
            fill_nxt_s = fill_r;
        end

        // A pattern load leaves the count alone even if cnt_clr is also high.
        if (pat_load) begin
            cnt_nxt_s = cnt_r;
        end else if (cnt_clr) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (hit_s && (cnt_r != CNT_MAX)) begin
            cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_r  <= RESET_PAT;
            hist_r <= {HW{1'b0}};
            fill_r <= 5'd0;
            cnt_r  <= {CNT_W{1'b0}};
            z_r    <= 1'b0;
        end else begin
            if (pat_load) begin
                pat_r <= pat_in;
            end else begin
                pat_r <= pat_r;
            end
            hist_r <= hist_nxt_s;
            fill_r <= fill_nxt_s;
            cnt_r  <= cnt_nxt_s;
            z_r    <= hit_s;
        end
    end

    // Output selection; Mealy hit is already gated off by reset and pat_load.
    always_comb begin
        z         = (MOORE != 0) ? z_r : hit_s;
        match_cnt = cnt_r;
        fill      = fill_r;
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: four parameter builds share one
// stimulus bus; each step queues the response expected from one build.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pat_load = 1'b0;
    logic [5:0] pat_in = 6'd0;
    logic       sym_valid = 1'b0;
    logic [1:0] sym_in = 2'd0;
    logic       cnt_clr = 1'b0;

    logic       z_s [4];
    logic [7:0] cnt_s [4];
    logic [4:0] fill_s [4];
    logic [1:0] cnt3_s;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int    dut;
        int    ez;
        int    ecnt;
        int    efill;
        string tag;
    } exp_t;

    exp_t sb_q[$];

    localparam logic [5:0] PAT_DEF = 6'b10_10_01;
    localparam logic [5:0] PAT_111 = 6'b01_01_01;

    always #5 clk = ~clk;

    seq_detector_param #(.OVERLAP(1), .MOORE(0), .CNT_W(8)) u_mealy (
        .clk(clk), .reset(reset), .pat_load(pat_load), .pat_in(pat_in),
        .sym_valid(sym_valid), .sym_in(sym_in), .cnt_clr(cnt_clr),
        .z(z_s[0]), .match_cnt(cnt_s[0]), .fill(fill_s[0]));

    seq_detector_param #(.OVERLAP(0), .MOORE(0), .CNT_W(8)) u_novl (
        .clk(clk), .reset(reset), .pat_load(pat_load), .pat_in(pat_in),
        .sym_valid(sym_valid), .sym_in(sym_in), .cnt_clr(cnt_clr),
        .z(z_s[1]), .match_cnt(cnt_s[1]), .fill(fill_s[1]));

    seq_detector_param #(.OVERLAP(1), .MOORE(1), .CNT_W(8)) u_moore (
        .clk(clk), .reset(reset), .pat_load(pat_load), .pat_in(pat_in),
        .sym_valid(sym_valid), .sym_in(sym_in), .cnt_clr(cnt_clr),
        .z(z_s[2]), .match_cnt(cnt_s[2]), .fill(fill_s[2]));

    seq_detector_param #(.OVERLAP(1), .MOORE(0), .CNT_W(2)) u_cnt2 (
        .clk(clk), .reset(reset), .pat_load(pat_load), .pat_in(pat_in),
        .sym_valid(sym_valid), .sym_in(sym_in), .cnt_clr(cnt_clr),
        .z(z_s[3]), .match_cnt(cnt3_s), .fill(fill_s[3]));

    assign cnt_s[3] = {6'd0, cnt3_s};

    // One cycle of stimulus; ecnt/efill are the registered values visible
    // during this cycle (state before this edge), -1 means not checked.
    task automatic step(input int d, input logic r, input logic ld, input logic [5:0] p,
                        input logic v, input logic [1:0] s, input logic c,
                        input int ez, input int ecnt, input int efill, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = r;
        pat_load  = ld;
        pat_in    = p;
        sym_valid = v;
        sym_in    = s;
        cnt_clr   = c;
        e.dut = d; e.ez = ez; e.ecnt = ecnt; e.efill = efill; e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic sym(input int d, input logic [1:0] s, input int ez, input int ec,
                       input int ef, input string tag);
        step(d, 1'b0, 1'b0, 6'd0, 1'b1, s, 1'b0, ez, ec, ef, tag);
    endtask

    task automatic idle(input int d, input int ez, input int ec, input int ef, input string tag);
        step(d, 1'b0, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, ez, ec, ef, tag);
    endtask

    task automatic rst();
        step(0, 1'b1, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, -1, -1, -1, "rst");
    endtask

    // Monitor: pops one expectation per cycle and compares away from the edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.ez >= 0) begin
                n_vec++;
                if (z_s[e.dut] !== e.ez[0]) begin
                    n_err++;
                    $display("FAIL %s z dut%0d: got %b want %0d", e.tag, e.dut, z_s[e.dut], e.ez);
                end
            end
            if (e.ecnt >= 0) begin
                n_vec++;
                if (cnt_s[e.dut] !== e.ecnt[7:0]) begin
                    n_err++;
                    $display("FAIL %s match_cnt dut%0d: got %0d want %0d", e.tag, e.dut, cnt_s[e.dut], e.ecnt);
                end
            end
            if (e.efill >= 0) begin
                n_vec++;
                if (fill_s[e.dut] !== e.efill[4:0]) begin
                    n_err++;
                    $display("FAIL %s fill dut%0d: got %0d want %0d", e.tag, e.dut, fill_s[e.dut], e.efill);
                end
            end
        end
    end

    initial begin
        // Defaults, Mealy with overlap: hits on symbols 3 and 6.
        rst();
        idle(0, 0, 0, 0, "a_reset");
        sym(0, 2'b01, 0, 0, 0, "a_s1");
        sym(0, 2'b10, 0, 0, 1, "a_s2");
        sym(0, 2'b10, 1, 0, 2, "a_s3");
        sym(0, 2'b01, 0, 1, 2, "a_s4");
        sym(0, 2'b10, 0, 1, 2, "a_s5");
        sym(0, 2'b10, 1, 1, 2, "a_s6");
        idle(0, 0, 2, 2, "a_end");

        // Overlapping 01,01,01 pattern: hits on symbols 3, 4, 5.
        rst();
        step(0, 1'b0, 1'b1, PAT_111, 1'b0, 2'd0, 1'b0, 0, 0, 0, "b_load");
        sym(0, 2'b01, 0, 0, 0, "b_s1");
        sym(0, 2'b01, 0, 0, 1, "b_s2");
        sym(0, 2'b01, 1, 0, 2, "b_s3");
        sym(0, 2'b01, 1, 1, 2, "b_s4");
        sym(0, 2'b01, 1, 2, 2, "b_s5");
        idle(0, 0, 3, 2, "b_end");

        // Non-overlapping: hits on symbols 3 and 6, history emptied after each.
        rst();
        step(1, 1'b0, 1'b1, PAT_111, 1'b0, 2'd0, 1'b0, 0, 0, 0, "c_load");
        sym(1, 2'b01, 0, 0, 0, "c_s1");
        sym(1, 2'b01, 0, 0, 1, "c_s2");
        sym(1, 2'b01, 1, 0, 2, "c_s3");
        sym(1, 2'b01, 0, 1, 0, "c_s4");
        sym(1, 2'b01, 0, 1, 1, "c_s5");
        sym(1, 2'b01, 1, 1, 2, "c_s6");
        idle(1, 0, 2, 0, "c_end");

        // Moore: pulse one cycle after the final symbol, back to back then gapped.
        rst();
        idle(2, 0, 0, 0, "d_reset");
        sym(2, 2'b01, 0, 0, 0, "d_s1");
        sym(2, 2'b10, 0, 0, 1, "d_s2");
        sym(2, 2'b10, 0, 0, 2, "d_s3");
        idle(2, 1, 1, 2, "d_pulse");
        idle(2, 0, 1, 2, "d_after");
        rst();
        idle(2, 0, 0, 0, "e_reset");
        sym(2, 2'b01, 0, 0, 0, "e_s1");
        for (int i = 0; i < 3; i++) idle(2, 0, 0, 1, "e_gap1");
        sym(2, 2'b10, 0, 0, 1, "e_s2");
        for (int i = 0; i < 3; i++) idle(2, 0, 0, 2, "e_gap2");
        sym(2, 2'b10, 0, 0, 2, "e_s3");
        idle(2, 1, 1, 2, "e_pulse");
        idle(2, 0, 1, 2, "e_after");
        // Reset arriving with the final symbol suppresses the Moore pulse.
        step(2, 1'b0, 1'b0, 6'd0, 1'b1, 2'b01, 1'b0, 0, 1, 2, "e_s4");
        sym(2, 2'b10, 0, 1, 2, "e_s5");
        step(2, 1'b1, 1'b0, 6'd0, 1'b1, 2'b10, 1'b0, 0, 1, 2, "e_rst_hit");
        idle(2, 0, 0, 0, "e_nopulse");

        // CNT_W=2: five matches saturate at 3.
        rst();
        for (int i = 0; i < 5; i++) begin
            int c;
            c = (i > 3) ? 3 : i;
            sym(3, 2'b01, 0, c, (i == 0) ? 0 : 2, "f_sat_a");
            sym(3, 2'b10, 0, c, (i == 0) ? 1 : 2, "f_sat_b");
            sym(3, 2'b10, 1, c, 2, "f_sat_hit");
        end
        idle(3, 0, 3, 2, "f_sat");
        // cnt_clr together with a hit: counter cleared, z still pulses.
        sym(3, 2'b01, 0, 3, 2, "g_s1");
        sym(3, 2'b10, 0, 3, 2, "g_s2");
        step(3, 1'b0, 1'b0, 6'd0, 1'b1, 2'b10, 1'b1, 1, 3, 2, "g_clr_hit");
        idle(3, 0, 0, 2, "g_cleared");
        // pat_load together with a final symbol: no z, history emptied.
        sym(3, 2'b01, 0, 0, 2, "h_s1");
        sym(3, 2'b10, 0, 0, 2, "h_s2");
        step(3, 1'b0, 1'b1, PAT_DEF, 1'b1, 2'b10, 1'b0, 0, 0, 2, "h_load_sym");
        idle(3, 0, 0, 0, "h_fill0");

        // Reset after a partial match discards it; a fresh sequence still matches.
        rst();
        idle(0, 0, 0, 0, "i_reset");
        sym(0, 2'b01, 0, 0, 0, "i_s1");
        sym(0, 2'b10, 0, 0, 1, "i_s2");
        step(0, 1'b1, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 0, 0, 2, "i_midrst");
        sym(0, 2'b10, 0, 0, 0, "i_s3");
        idle(0, 0, 0, 1, "i_nomatch");
        sym(0, 2'b01, 0, 0, 1, "i_s4");
        sym(0, 2'b10, 0, 0, 2, "i_s5");
        sym(0, 2'b10, 1, 0, 2, "i_s6");
        idle(0, 0, 1, 2, "i_end");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
